// File: rtl/credit_pkg.sv
// credit_pkg: shared types and default parameters for the credit accumulator.
//   state_t          refund state machine encoding (IDLE, REFUND)
//   DEF_WIDTH        default credit/coin/price width in bits
//   DEF_MAX_CREDIT   default saturation ceiling
//   DEF_CHANGE_UNIT  default credit value of one change coin
package credit_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFUND = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_MAX_CREDIT  = 200;
  localparam int unsigned DEF_CHANGE_UNIT = 5;

endpackage

// File: rtl/credit_refund_fsm.sv
// credit_refund_fsm: IDLE/REFUND control for the credit accumulator.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_ld               credit load this cycle: forces IDLE, suppresses done
//   i_refund           refund request (acted on in IDLE only)
//   i_credit           registered credit from the datapath
//   o_refund_c         current state is REFUND (decoded from state register)
//   o_change_vld_c     one change coin offered (decoded from registers only)
//   o_busy             high in every REFUND cycle
//   o_refund_done      one-cycle pulse in the first IDLE cycle after REFUND
module credit_refund_fsm
  import credit_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned CHANGE_UNIT = DEF_CHANGE_UNIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic             i_refund,
  input  logic [WIDTH-1:0] i_credit,
  output logic             o_refund_c,
  output logic             o_change_vld_c,
  output logic             o_busy,
  output logic             o_refund_done
);

  localparam int unsigned     EW       = WIDTH + 1;
  localparam logic [EW-1:0]   UNIT_EXT = EW'(CHANGE_UNIT);

  state_t state, state_next;
  logic   busy_next, done_next;
  logic   credit_ge_unit;

  assign credit_ge_unit = ({1'b0, i_credit} >= UNIT_EXT);

  // State and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_busy        <= 1'b0;
      o_refund_done <= 1'b0;
    end else begin
      state         <= state_next;
      o_busy        <= busy_next;
      o_refund_done <= done_next;
    end
  end

  // Next state; exit decision uses the registered credit, so the last
  // REFUND cycle is the one where credit already sits below one unit
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    if (i_ld) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:   if (i_refund) state_next = REFUND;
        REFUND: begin
          if (!credit_ge_unit) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next = (state_next == REFUND);
  end

  assign o_refund_c     = (state == REFUND);
  assign o_change_vld_c = o_refund_c && credit_ge_unit;

endmodule

// File: rtl/credit_accumulator.sv
// credit_accumulator: saturating credit register with vend debit and refund.
// Optional feature macro: CREDIT_LOAD_EN adds i_ld / i_ld_val direct load.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_coin_vld, i_coin_val    coin inserted this cycle and its value
//   i_vend_req, i_price       purchase request and item price
//   i_refund                  start change return
//   i_change_rdy              dispenser accepts one change coin
//   i_ld, i_ld_val            direct credit load (CREDIT_LOAD_EN only)
//   o_credit                  current credit
//   o_vend_ack, o_vend_nack   purchase accepted / refused (pulse)
//   o_coin_rej                coin refused (pulse)
//   o_sat                     coin clipped at MAX_CREDIT (pulse)
//   o_change_vld              one change coin offered (register-decoded)
//   o_busy                    refund in progress
//   o_refund_done             refund finished (pulse)
module credit_accumulator
  import credit_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int unsigned CHANGE_UNIT = DEF_CHANGE_UNIT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_coin_vld,
  input  logic [WIDTH-1:0] i_coin_val,
  input  logic             i_vend_req,
  input  logic [WIDTH-1:0] i_price,
  input  logic             i_refund,
  input  logic             i_change_rdy,
`ifdef CREDIT_LOAD_EN
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_ld_val,
`endif
  output logic [WIDTH-1:0] o_credit,
  output logic             o_vend_ack,
  output logic             o_vend_nack,
  output logic             o_coin_rej,
  output logic             o_sat,
  output logic             o_change_vld,
  output logic             o_busy,
  output logic             o_refund_done
);

  localparam int unsigned   EW       = WIDTH + 1;
  localparam logic [EW-1:0] MAX_EXT  = EW'(MAX_CREDIT);
  localparam logic [EW-1:0] UNIT_EXT = EW'(CHANGE_UNIT);

  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             in_refund_c;
  logic             change_vld_c;
  logic [EW-1:0]    credit_ext, after_debit, sum;
  logic [WIDTH-1:0] credit_next;
  logic             ack_next, nack_next, rej_next, sat_next;

`ifdef CREDIT_LOAD_EN
  assign ld     = i_ld;
  assign ld_val = i_ld_val;
`else
  assign ld     = 1'b0;
  assign ld_val = '0;
`endif

  credit_refund_fsm #(
    .WIDTH       (WIDTH),
    .CHANGE_UNIT (CHANGE_UNIT)
  ) u_fsm (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_ld           (ld),
    .i_refund       (i_refund),
    .i_credit       (o_credit),
    .o_refund_c     (in_refund_c),
    .o_change_vld_c (change_vld_c),
    .o_busy         (o_busy),
    .o_refund_done  (o_refund_done)
  );

  assign o_change_vld = change_vld_c;
  assign credit_ext   = {1'b0, o_credit};

  // Credit datapath; one extra bit keeps debit/add/clip free of wrap-around
  always_comb begin
    credit_next = o_credit;
    ack_next    = 1'b0;
    nack_next   = 1'b0;
    rej_next    = 1'b0;
    sat_next    = 1'b0;
    after_debit = credit_ext;
    sum         = credit_ext;
    if (ld) begin
      credit_next = ({1'b0, ld_val} > MAX_EXT) ? WIDTH'(MAX_CREDIT) : ld_val;
      rej_next    = i_coin_vld;
    end else if (in_refund_c) begin
      rej_next  = i_coin_vld;
      nack_next = i_vend_req;
      if (change_vld_c && i_change_rdy) credit_next = WIDTH'(credit_ext - UNIT_EXT);
    end else begin
      // Vend is judged on registered credit only; a same-cycle coin never funds it
      if (i_vend_req) begin
        if (credit_ext >= {1'b0, i_price}) begin
          ack_next    = 1'b1;
          after_debit = credit_ext - {1'b0, i_price};
        end else begin
          nack_next = 1'b1;
        end
      end
      sum = after_debit + (i_coin_vld ? {1'b0, i_coin_val} : EW'(0));
      if (sum > MAX_EXT) begin
        credit_next = WIDTH'(MAX_CREDIT);
        sat_next    = 1'b1;
      end else begin
        credit_next = WIDTH'(sum);
      end
    end
  end

  // Registered credit and response pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_credit    <= '0;
      o_vend_ack  <= 1'b0;
      o_vend_nack <= 1'b0;
      o_coin_rej  <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      o_credit    <= credit_next;
      o_vend_ack  <= ack_next;
      o_vend_nack <= nack_next;
      o_coin_rej  <= rej_next;
      o_sat       <= sat_next;
    end
  end

endmodule

// File: tb/tb_credit_accumulator.sv
// tb_credit_accumulator: scoreboard bench for credit_accumulator (defaults
// WIDTH=8, MAX_CREDIT=200, CHANGE_UNIT=5). With CREDIT_LOAD_EN defined the
// load port is connected and exercised as well.
module tb_credit_accumulator;

  typedef struct packed {
    logic       rst;
    logic       coin_vld;
    logic [7:0] coin_val;
    logic       vend;
    logic [7:0] price;
    logic       refund;
    logic       rdy;
    logic       ld;
    logic [7:0] ld_val;
  } stim_t;

  // flags order: ack, nack, rej, sat, chg, busy, done
  typedef struct packed {
    logic [7:0] credit;
    logic       ack;
    logic       nack;
    logic       rej;
    logic       sat;
    logic       chg;
    logic       busy;
    logic       done;
  } obs_t;

  logic       i_clk = 1'b0;
  logic       i_rst, i_coin_vld, i_vend_req, i_refund, i_change_rdy;
  logic [7:0] i_coin_val, i_price;
  logic       i_ld;
  logic [7:0] i_ld_val;
  logic [7:0] o_credit;
  logic       o_vend_ack, o_vend_nack, o_coin_rej, o_sat;
  logic       o_change_vld, o_busy, o_refund_done;

  always #5 i_clk = ~i_clk;

  credit_accumulator dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_coin_vld    (i_coin_vld),
    .i_coin_val    (i_coin_val),
    .i_vend_req    (i_vend_req),
    .i_price       (i_price),
    .i_refund      (i_refund),
    .i_change_rdy  (i_change_rdy),
`ifdef CREDIT_LOAD_EN
    .i_ld          (i_ld),
    .i_ld_val      (i_ld_val),
`endif
    .o_credit      (o_credit),
    .o_vend_ack    (o_vend_ack),
    .o_vend_nack   (o_vend_nack),
    .o_coin_rej    (o_coin_rej),
    .o_sat         (o_sat),
    .o_change_vld  (o_change_vld),
    .o_busy        (o_busy),
    .o_refund_done (o_refund_done)
  );

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t got, exp_o;

  // Reference model state
  int m_credit  = 0;
  bit m_refund  = 1'b0;
  bit ld_enable = 1'b0;

  function automatic stim_t mk(input bit rst, input bit cv, input int cval,
                               input bit vend, input int price,
                               input bit refund, input bit rdy);
    stim_t s;
    s          = '0;
    s.rst      = rst;
    s.coin_vld = cv;
    s.coin_val = 8'(cval);
    s.vend     = vend;
    s.price    = 8'(price);
    s.refund   = refund;
    s.rdy      = rdy;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.credit = o_credit;
    o.ack    = o_vend_ack;
    o.nack   = o_vend_nack;
    o.rej    = o_coin_rej;
    o.sat    = o_sat;
    o.chg    = o_change_vld;
    o.busy   = o_busy;
    o.done   = o_refund_done;
    return o;
  endfunction

  // Drive one cycle, push the model's expectation, advance past the edge
  task automatic apply(input stim_t s);
    obs_t e;
    int   t;
    i_rst        = s.rst;
    i_coin_vld   = s.coin_vld;
    i_coin_val   = s.coin_val;
    i_vend_req   = s.vend;
    i_price      = s.price;
    i_refund     = s.refund;
    i_change_rdy = s.rdy;
    i_ld         = s.ld;
    i_ld_val     = s.ld_val;
    e = '0;
    if (s.rst) begin
      m_credit = 0;
      m_refund = 1'b0;
    end else if (ld_enable && s.ld) begin
      m_credit = (int'(s.ld_val) > 200) ? 200 : int'(s.ld_val);
      e.rej    = s.coin_vld;
      m_refund = 1'b0;
    end else if (!m_refund) begin
      t = m_credit;
      if (s.vend) begin
        if (m_credit >= int'(s.price)) begin
          e.ack = 1'b1;
          t     = t - int'(s.price);
        end else begin
          e.nack = 1'b1;
        end
      end
      if (s.coin_vld) t = t + int'(s.coin_val);
      if (t > 200) begin
        t     = 200;
        e.sat = 1'b1;
      end
      m_credit = t;
      if (s.refund) m_refund = 1'b1;
    end else begin
      e.rej  = s.coin_vld;
      e.nack = s.vend;
      if (m_credit >= 5) begin
        if (s.rdy) m_credit = m_credit - 5;
      end else begin
        m_refund = 1'b0;
        e.done   = 1'b1;
      end
    end
    e.credit = 8'(m_credit);
    e.busy   = m_refund;
    e.chg    = m_refund && (m_credit >= 5);
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t v[$];
    v.push_back(mk(1, 1, 77, 1, 3, 1, 1));
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL reset[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
    end
    n_vec++;
    if (o_credit !== 8'd0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_const: got credit=%0d busy=%b, required 0/0", o_credit, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 100, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 50, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 60, 1, 100, 0, 0));  // debit 100 then add 60 -> 110
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL coins[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
    end
    n_vec++;
    if (o_credit !== 8'd110 || o_vend_ack !== 1'b1) begin
      n_err++;
      $display("FAIL coins_const: got credit=%0d ack=%b, required 110/1", o_credit, o_vend_ack);
    end
  endtask

  task automatic test_saturation();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 190, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 25, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 0, 0, 0));   // at ceiling, zero coin: no clip
    v.push_back(mk(0, 1, 255, 0, 0, 0, 0)); // largest coin at ceiling
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL sat[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
      if (i == 2) begin
        n_vec++;
        if (o_credit !== 8'd200 || o_sat !== 1'b1) begin
          n_err++;
          $display("FAIL sat_const: got credit=%0d sat=%b, required 200/1", o_credit, o_sat);
        end
      end
    end
  endtask

  task automatic test_vend();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 30, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 40, 0, 0));   // nack, 30
    v.push_back(mk(0, 1, 20, 1, 35, 0, 0));  // coin cannot fund: nack, 50
    v.push_back(mk(0, 0, 0, 1, 50, 0, 0));   // exact price: ack, 0
    v.push_back(mk(0, 0, 0, 1, 0, 0, 0));    // zero price at zero credit: ack
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL vend[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
      if (i == 3) begin
        n_vec++;
        if (o_credit !== 8'd50 || o_vend_nack !== 1'b1) begin
          n_err++;
          $display("FAIL vend_const: got credit=%0d nack=%b, required 50/1", o_credit, o_vend_nack);
        end
      end
    end
  endtask

  task automatic test_refund_full();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 23, 0, 0, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < 6; k++) v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL refund[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
      if (i == 7) begin
        n_vec++;
        if (o_credit !== 8'd3 || o_refund_done !== 1'b1 || o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL refund_const: got credit=%0d done=%b busy=%b, required 3/1/0",
                   o_credit, o_refund_done, o_busy);
        end
      end
    end
  endtask

  task automatic test_refund_small();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 4, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1));   // refund ignored in REFUND
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL refund_small[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
    end
  endtask

  task automatic test_refund_toggle();
    stim_t v[$];
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 20, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));   // 15
    v.push_back(mk(0, 1, 10, 0, 0, 0, 0));  // coin rejected, 15
    v.push_back(mk(0, 0, 0, 1, 1, 0, 1));   // vend nacked, 10
    v.push_back(mk(0, 0, 0, 0, 0, 0, 0));   // 10
    v.push_back(mk(1, 0, 0, 0, 0, 0, 1));   // reset mid-refund
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));   // no done pulse
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL toggle[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
      if (i == 4) begin
        n_vec++;
        if (o_credit !== 8'd15 || o_coin_rej !== 1'b1) begin
          n_err++;
          $display("FAIL toggle_const: got credit=%0d rej=%b, required 15/1", o_credit, o_coin_rej);
        end
      end
    end
  endtask

`ifdef CREDIT_LOAD_EN
  task automatic test_load();
    stim_t v[$];
    stim_t s;
    v.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 40, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    s = mk(0, 1, 10, 1, 5, 0, 1);
    s.ld = 1'b1;
    s.ld_val = 8'd250;
    v.push_back(s);
    v.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    s = mk(0, 0, 0, 0, 0, 0, 0);
    s.ld = 1'b1;
    s.ld_val = 8'd17;
    v.push_back(s);
    foreach (v[i]) begin
      apply(v[i]);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL load[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
      if (i == 4) begin
        n_vec++;
        if (o_credit !== 8'd200 || o_coin_rej !== 1'b1 || o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL load_const: got credit=%0d rej=%b busy=%b, required 200/1/0",
                   o_credit, o_coin_rej, o_busy);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = mk(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 4),
             int'($urandom_range(0, 120)), ($urandom_range(0, 9) < 3),
             int'($urandom_range(0, 120)), ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 9) < 6));
      if (ld_enable && $urandom_range(0, 39) == 0) begin
        s.ld     = 1'b1;
        s.ld_val = 8'($urandom_range(0, 255));
      end
      apply(s);
      exp_o = exp_q.pop_front();
      got   = sample();
      n_vec++;
      if (got !== exp_o) begin
        n_err++;
        $display("FAIL random[%0d]: got credit=%0d flags=%b, required credit=%0d flags=%b",
                 i, got.credit, got[6:0], exp_o.credit, exp_o[6:0]);
      end
    end
  endtask

  initial begin
`ifdef CREDIT_LOAD_EN
    ld_enable = 1'b1;
`endif
    i_rst        = 1'b1;
    i_coin_vld   = 1'b0;
    i_coin_val   = '0;
    i_vend_req   = 1'b0;
    i_price      = '0;
    i_refund     = 1'b0;
    i_change_rdy = 1'b0;
    i_ld         = 1'b0;
    i_ld_val     = '0;
    @(posedge i_clk);
    #1;
    test_reset();
    test_back_to_back();
    test_saturation();
    test_vend();
    test_refund_full();
    test_refund_small();
    test_refund_toggle();
`ifdef CREDIT_LOAD_EN
    test_load();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
